// File: rtl/fpga_inputs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpga_inputs_pkg
// Purpose  : Shared types and constants for the fpga_inputs trigger sequencer:
//            FSM state encoding, 3-bit step index, default timing constants
//            and small helper functions.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package fpga_inputs_pkg;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Eight trigger outputs, addressed by a 3-bit step index
    typedef logic [2:0] step_t;

    localparam int c_def_clk_div   = 2;
    localparam int c_def_startup   = 16;
    localparam int c_def_pulse_len = 8;
    localparam int c_def_gap       = 4;

    // Counter width large enough to hold (value - 1); never narrower than 1
    function automatic int cnt_width(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One-hot select of the trigger addressed by a step index
    function automatic logic [7:0] step_onehot(input step_t step);
        return 8'b0000_0001 << step;
    endfunction

endpackage : fpga_inputs_pkg
`default_nettype wire

// File: rtl/clk_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_divider
// Purpose  : Registered 50% duty clock divider, Clk_out = Clk / CLK_DIV.
//            Clk_out toggles every CLK_DIV/2 rising edges of Clk, the first
//            toggle landing on edge CLK_DIV/2 after reset release.
// Ports    : Clk     - input clock
//            Reset   - asynchronous active-low reset
//            Clk_out - divided clock, low while in reset
// Revision : 1.0 - initial release
// ============================================================================
module clk_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Reset,
    output logic Clk_out
);

    localparam int c_half  = CLK_DIV / 2;
    localparam int c_cnt_w = (c_half > 1) ? $clog2(c_half) : 1;
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_clk_out;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
        end else if (r_cnt == c_half_last) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
        end else begin
            r_cnt     <= r_cnt + c_one;
        end
    end

    assign Clk_out = r_clk_out;

endmodule : clk_divider
`default_nettype wire

// File: rtl/fpga_inputs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpga_inputs
// Purpose  : Startup-delayed round-robin trigger sequencer. After STARTUP
//            cycles it raises ready_out and then pulses each of the eight
//            trigger outputs in turn for PULSE_LEN cycles, separated by GAP
//            all-low cycles, repeating forever. Also provides a divided clock.
// Ports    : Clk                 - sole clock, rising edge
//            Reset               - asynchronous active-low reset
//            Clk_out             - Clk / CLK_DIV, 50% duty
//            DRV_*_Out           - drive up/down triggers
//            PSG_Front_*_Out     - front pressure-group triggers
//            PSG_BackL_*_Out     - back-left pressure-group triggers
//            PSG_BackR_*_Out     - back-right pressure-group triggers
//            ready_out           - high from end of startup until next reset
// Revision : 1.0 - initial release
// ============================================================================
module fpga_inputs
    import fpga_inputs_pkg::*;
#(
    parameter int CLK_DIV   = c_def_clk_div,
    parameter int STARTUP   = c_def_startup,
    parameter int PULSE_LEN = c_def_pulse_len,
    parameter int GAP       = c_def_gap
) (
    input  logic Clk,
    input  logic Reset,
    output logic Clk_out,
    output logic DRV_Up_Out,
    output logic DRV_Down_Out,
    output logic PSG_Front_Up_Out,
    output logic PSG_Front_Down_Out,
    output logic PSG_BackL_Up_Out,
    output logic PSG_BackL_Down_Out,
    output logic PSG_BackR_Up_Out,
    output logic PSG_BackR_Down_Out,
    output logic ready_out
);

    localparam int c_cnt_w = cnt_width(max3(STARTUP, PULSE_LEN, GAP));
    localparam logic [c_cnt_w-1:0] c_startup_last = c_cnt_w'(STARTUP - 1);
    localparam logic [c_cnt_w-1:0] c_pulse_last   = c_cnt_w'(PULSE_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'(GAP - 1);
    localparam logic [c_cnt_w-1:0] c_one          = c_cnt_w'(1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    step_t              r_step;
    logic [7:0]         r_trig;
    logic               r_ready;
    step_t              w_next_step;

    // Step 7 rolls straight over to step 0: the 3-bit index wraps naturally
    assign w_next_step = r_step + 3'd1;

    clk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_divider (
        .Clk     (Clk),
        .Reset   (Reset),
        .Clk_out (Clk_out)
    );

    // Trigger outputs are loaded on the same edge as the state change that
    // starts or ends a pulse, so the pins are registered and transition
    // exactly on the FSM boundary edges.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_step  <= '0;
            r_trig  <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_cnt == c_startup_last) begin
                        r_state <= S_PULSE;
                        r_cnt   <= '0;
                        r_step  <= '0;
                        r_trig  <= step_onehot(3'd0);
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + c_one;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == c_pulse_last) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                        r_trig  <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_one;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_state <= S_PULSE;
                        r_cnt   <= '0;
                        r_step  <= w_next_step;
                        r_trig  <= step_onehot(w_next_step);
                    end else begin
                        r_cnt   <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_cnt   <= '0;
                    r_step  <= '0;
                    r_trig  <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign DRV_Up_Out         = r_trig[0];
    assign DRV_Down_Out       = r_trig[1];
    assign PSG_Front_Up_Out   = r_trig[2];
    assign PSG_Front_Down_Out = r_trig[3];
    assign PSG_BackL_Up_Out   = r_trig[4];
    assign PSG_BackL_Down_Out = r_trig[5];
    assign PSG_BackR_Up_Out   = r_trig[6];
    assign PSG_BackR_Down_Out = r_trig[7];
    assign ready_out          = r_ready;

endmodule : fpga_inputs
`default_nettype wire

// File: tb/tb_fpga_inputs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fpga_inputs
// Purpose  : Self-checking bench for fpga_inputs. One instance with default
//            parameters, one with CLK_DIV=4, STARTUP=3, PULSE_LEN=1, GAP=1.
//            Expected outputs come from a timing model built from the edge
//            count since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_inputs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    logic       a_clk_out, a_ready;
    logic [7:0] a_trig;
    logic       b_clk_out, b_ready;
    logic [7:0] b_trig;

    int n_checks = 0;
    int n_fail   = 0;

    fpga_inputs u_dut_a (
        .Clk                (clk),
        .Reset              (rst_a),
        .Clk_out            (a_clk_out),
        .DRV_Up_Out         (a_trig[0]),
        .DRV_Down_Out       (a_trig[1]),
        .PSG_Front_Up_Out   (a_trig[2]),
        .PSG_Front_Down_Out (a_trig[3]),
        .PSG_BackL_Up_Out   (a_trig[4]),
        .PSG_BackL_Down_Out (a_trig[5]),
        .PSG_BackR_Up_Out   (a_trig[6]),
        .PSG_BackR_Down_Out (a_trig[7]),
        .ready_out          (a_ready)
    );

    fpga_inputs #(
        .CLK_DIV   (4),
        .STARTUP   (3),
        .PULSE_LEN (1),
        .GAP       (1)
    ) u_dut_b (
        .Clk                (clk),
        .Reset              (rst_b),
        .Clk_out            (b_clk_out),
        .DRV_Up_Out         (b_trig[0]),
        .DRV_Down_Out       (b_trig[1]),
        .PSG_Front_Up_Out   (b_trig[2]),
        .PSG_Front_Down_Out (b_trig[3]),
        .PSG_BackL_Up_Out   (b_trig[4]),
        .PSG_BackL_Down_Out (b_trig[5]),
        .PSG_BackR_Up_Out   (b_trig[6]),
        .PSG_BackR_Down_Out (b_trig[7]),
        .ready_out          (b_ready)
    );

    wire [9:0] w_obs_a = {a_clk_out, a_ready, a_trig};
    wire [9:0] w_obs_b = {b_clk_out, b_ready, b_trig};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected {Clk_out, ready_out, trig[7:0]} after rising edge e (e=0: none yet)
    function automatic logic [9:0] model(input int e, input int div, input int st,
                                         input int pl, input int gp);
        logic [7:0] trig;
        logic       ck;
        logic       rdy;
        int         t;
        trig = 8'h00;
        ck   = ((e / (div / 2)) % 2) == 1;
        rdy  = (e >= st);
        if (e >= st) begin
            t = (e - st) % (8 * (pl + gp));
            if ((t % (pl + gp)) < pl) trig = 8'h01 << (t / (pl + gp));
        end
        return {ck, rdy, trig};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Held in reset for 100 ns: every output must stay low
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("reset_hold_a", {22'd0, w_obs_a}, 32'd0);
            check_val("reset_hold_b", {22'd0, w_obs_b}, 32'd0);
        end

        // Release away from the active edge; next rising edge is edge 1
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int e = 1; e <= 230; e++) begin
            tick();
            check_val($sformatf("run_a_e%0d", e), {22'd0, w_obs_a}, {22'd0, model(e, 2, 16, 8, 4)});
            check_val($sformatf("run_b_e%0d", e), {22'd0, w_obs_b}, {22'd0, model(e, 4, 3, 1, 1)});
            check_val("onehot_a", {31'd0, $countones(a_trig) <= 1}, 32'd1);
        end

        // Asynchronous assertion between edges clears outputs immediately
        rst_a = 1'b0;
        #1;
        check_val("async_rst_a", {22'd0, w_obs_a}, 32'd0);

        @(negedge clk);
        rst_a = 1'b1;
        for (int e = 1; e <= 42; e++) begin
            tick();
            check_val($sformatf("pre_mid_a_e%0d", e), {22'd0, w_obs_a}, {22'd0, model(e, 2, 16, 8, 4)});
        end
        check_val("front_up_before_rst", {31'd0, a_trig[2]}, 32'd1);

        // Reset mid-pulse, hold 50 ns
        #1;
        rst_a = 1'b0;
        #1;
        check_val("mid_pulse_rst_a", {22'd0, w_obs_a}, 32'd0);
        #24;
        check_val("mid_pulse_hold_a", {22'd0, w_obs_a}, 32'd0);
        #24;
        @(negedge clk);
        rst_a = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            check_val($sformatf("post_rst_a_e%0d", e), {22'd0, w_obs_a}, {22'd0, model(e, 2, 16, 8, 4)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fpga_inputs
`default_nettype wire
